// File: rtl/branch_pc_unit_pkg.sv
// Shared encodings for the fetch-side PC / branch redirect stage.
package branch_pc_unit_pkg;

  // Stage state encoding
  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_FLUSH = 2'd1;
  localparam logic [1:0] ST_HALT  = 2'd2;

  // Opcodes seen in decode
  localparam logic [3:0] OP_B    = 4'hB;
  localparam logic [3:0] OP_HALT = 4'hF;

  // Condition encodings (evaluated by flag_rf, carried in instr[10:8])
  localparam logic [2:0] COND_ALWAYS   = 3'd0;
  localparam logic [2:0] COND_EQUAL    = 3'd1;
  localparam logic [2:0] COND_NOTEQUAL = 3'd2;
  localparam logic [2:0] COND_LESS     = 3'd3;

  // Opcode field of a decode-stage instruction
  function automatic logic [3:0] instr_op(input logic [15:0] ins);
    return ins[15:12];
  endfunction

endpackage

// File: rtl/branch_pc_unit_pc_target_adder.sv
// Branch target: decode PC + 1 + sign-extended 8-bit word offset, modulo 2^PC_W.
module pc_target_adder #(
  parameter int PC_W = 16
) (
  input  logic [PC_W-1:0] base,
  input  logic [7:0]      off,
  output logic [PC_W-1:0] target
);

  localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

  logic [PC_W-1:0] off_ext;

  // Sign-extend the offset so negative displacements wrap below zero
  assign off_ext = {{(PC_W-8){off[7]}}, off};
  assign target  = base + PC_ONE + off_ext;

endmodule

// File: rtl/branch_pc_unit.sv
// Fetch program counter with taken-branch redirect, wrong-path squash,
// HALT stop and a saturating taken-branch counter.
module branch_pc_unit
  import branch_pc_unit_pkg::*;
#(
  parameter int              PC_W         = 16,
  parameter logic [PC_W-1:0] RESET_PC     = '0,
  parameter int              FLUSH_CYCLES = 1,
  parameter logic [3:0]      HALT_OP      = OP_HALT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic [15:0]     instr,
  input  logic            instr_valid,
  input  logic            branch_taken,
  output logic [PC_W-1:0] pc,
  output logic            pc_valid,
  output logic            flush,
  output logic            halted,
  output logic [15:0]     taken_cnt
);

  localparam logic [PC_W-1:0] PC_ONE    = {{(PC_W-1){1'b0}}, 1'b1};
  localparam logic [2:0]      FCNT_LOAD = 3'(FLUSH_CYCLES - 1);

  logic [1:0]      state;
  logic [2:0]      fcnt;
  logic [PC_W-1:0] dec_pc;
  logic [PC_W-1:0] target_pc;
  logic            is_taken_b;
  logic            is_halt;
  logic            unused_instr_bits;

  // x and cond fields are consumed by flag_rf, not here
  assign unused_instr_bits = ^instr[11:8];

  assign is_taken_b = instr_valid && (instr_op(instr) == OP_B) && branch_taken;
  assign is_halt    = instr_valid && (instr_op(instr) == HALT_OP);

  pc_target_adder #(.PC_W(PC_W)) u_target (
    .base   (dec_pc),
    .off    (instr[7:0]),
    .target (target_pc)
  );

  // PC / redirect state machine; stall freezes every register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_RUN;
      fcnt      <= 3'd0;
      pc        <= RESET_PC;
      dec_pc    <= RESET_PC;
      pc_valid  <= 1'b0;
      flush     <= 1'b0;
      halted    <= 1'b0;
      taken_cnt <= 16'd0;
    end else if (!stall) begin
      case (state)
        ST_RUN: begin
          dec_pc <= pc;
          if (is_taken_b) begin
            pc       <= target_pc;
            pc_valid <= 1'b1;
            flush    <= 1'b1;
            fcnt     <= FCNT_LOAD;
            state    <= ST_FLUSH;
            if (taken_cnt != 16'hFFFF) taken_cnt <= taken_cnt + 16'd1;
          end else if (is_halt) begin
            pc_valid <= 1'b0;
            halted   <= 1'b1;
            state    <= ST_HALT;
          end else begin
            // First cycle out of reset only raises pc_valid so RESET_PC is fetched
            pc_valid <= 1'b1;
            if (pc_valid) pc <= pc + PC_ONE;
          end
        end
        ST_FLUSH: begin
          dec_pc <= pc;
          pc     <= pc + PC_ONE;
          if (fcnt == 3'd0) begin
            flush <= 1'b0;
            state <= ST_RUN;
          end else begin
            fcnt <= fcnt - 3'd1;
          end
        end
        ST_HALT: begin
          // Sticky until reset
        end
        default: state <= ST_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_branch_pc_unit.sv
// Scoreboard bench: the driver pushes hand-computed expected outputs per
// clock, a monitor pops and compares them on the falling edge.
module tb_branch_pc_unit;
  import branch_pc_unit_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic [15:0] instr;
  logic        instr_valid;
  logic        branch_taken;
  logic [15:0] pc;
  logic        pc_valid;
  logic        flush;
  logic        halted;
  logic [15:0] taken_cnt;

  typedef struct packed {
    logic [15:0] pc;
    logic        v;
    logic        f;
    logic        h;
    logic [15:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  branch_pc_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall        (stall),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .branch_taken (branch_taken),
    .pc           (pc),
    .pc_valid     (pc_valid),
    .flush        (flush),
    .halted       (halted),
    .taken_cnt    (taken_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] mk_b(input logic [7:0] off);
    return {OP_B, 1'b0, COND_EQUAL, off};
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Drive one cycle of inputs and queue the outputs expected after the edge
  task automatic step(input logic r, input logic s, input logic iv, input logic [15:0] ins,
                      input logic tk, input logic [15:0] e_pc, input logic e_v,
                      input logic e_f, input logic e_h, input logic [15:0] e_cnt);
    exp_t e;
    rst_n        = r;
    stall        = s;
    instr_valid  = iv;
    instr        = ins;
    branch_taken = tk;
    e.pc = e_pc; e.v = e_v; e.f = e_f; e.h = e_h; e.cnt = e_cnt;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Monitor: one expectation per clock, compared mid-cycle
  initial begin
    exp_t e;
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        $display("t=%0t pc=%h valid=%b flush=%b halted=%b cnt=%0d", $time, pc, pc_valid, flush, halted, taken_cnt);
        check("pc", pc, e.pc);
        check("pc_valid", {15'd0, pc_valid}, {15'd0, e.v});
        check("flush", {15'd0, flush}, {15'd0, e.f});
        check("halted", {15'd0, halted}, {15'd0, e.h});
        check("taken_cnt", taken_cnt, e.cnt);
      end
    end
  end

  initial begin
    logic [15:0] nop;
    logic [15:0] hlt;
    int          waited;
    nop = 16'h0000;
    hlt = {OP_HALT, 12'h000};

    // Reset
    step(0, 0, 0, nop, 0, 16'h0000, 0, 0, 0, 16'd0);
    step(0, 0, 0, nop, 0, 16'h0000, 0, 0, 0, 16'd0);
    // Sequential fetch from RESET_PC, run until pc=0x11 (dec_pc=0x10)
    step(1, 0, 0, nop, 0, 16'h0000, 1, 0, 0, 16'd0);
    for (int i = 1; i <= 17; i++)
      step(1, 0, 0, nop, 0, 16'(i), 1, 0, 0, 16'd0);

    // Taken B +5 from dec_pc 0x10 -> 0x16, one flush cycle (instr ignored in FLUSH)
    step(1, 0, 1, mk_b(8'h05), 1, 16'h0016, 1, 1, 0, 16'd1);
    step(1, 0, 1, mk_b(8'h05), 1, 16'h0017, 1, 0, 0, 16'd1);
    // Not-taken B: sequential, dec_pc=0x16 -> pc=0x18
    step(1, 0, 1, mk_b(8'h05), 0, 16'h0018, 1, 0, 0, 16'd1);
    // Taken flag on a bubble: sequential
    step(1, 0, 0, mk_b(8'h05), 1, 16'h0019, 1, 0, 0, 16'd1);

    // Backward branch from dec_pc 0x18 to 0x0002 (off=-0x17)
    step(1, 0, 1, mk_b(8'hE9), 1, 16'h0002, 1, 1, 0, 16'd2);
    step(1, 0, 0, nop, 0, 16'h0003, 1, 0, 0, 16'd2);
    // dec_pc=2, off=-4 -> 0xFFFF, then wrap to 0x0000
    step(1, 0, 1, mk_b(8'hFC), 1, 16'hFFFF, 1, 1, 0, 16'd3);
    step(1, 0, 0, nop, 0, 16'h0000, 1, 0, 0, 16'd3);
    step(1, 0, 0, nop, 0, 16'h0001, 1, 0, 0, 16'd3);

    // Taken B held under stall for 3 cycles (dec_pc=0), then redirect to 6
    for (int i = 0; i < 3; i++)
      step(1, 1, 1, mk_b(8'h05), 1, 16'h0001, 1, 0, 0, 16'd3);
    step(1, 0, 1, mk_b(8'h05), 1, 16'h0006, 1, 1, 0, 16'd4);
    // Stall during FLUSH freezes it
    step(1, 1, 0, nop, 0, 16'h0006, 1, 1, 0, 16'd4);
    step(1, 0, 0, nop, 0, 16'h0007, 1, 0, 0, 16'd4);

    // HALT: pc frozen, pc_valid drops, sticky even against taken branches
    step(1, 0, 1, hlt, 0, 16'h0007, 0, 0, 1, 16'd4);
    for (int i = 0; i < 10; i++)
      step(1, 0, 1, mk_b(8'h05), 1, 16'h0007, 0, 0, 1, 16'd4);
    // Reset clears everything
    step(0, 0, 0, nop, 0, 16'h0000, 0, 0, 0, 16'd0);
    step(1, 0, 0, nop, 0, 16'h0000, 1, 0, 0, 16'd0);
    step(1, 0, 0, nop, 0, 16'h0001, 1, 0, 0, 16'd0);

    // Drain scoreboard with a bounded wait
    waited = 0;
    while (exp_q.size() > 0 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    #1;
    if (exp_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
